// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: datapath width, reset/NOP defaults, PC step
// and the next-PC source select.
package pipeline_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = '0;
   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = '0;
   localparam logic [XLEN-1:0] PC_STEP           = 32'd4;
   localparam logic [XLEN-1:0] PC_LOW_MASK       = PC_STEP - 32'd1;

   typedef enum logic [1:0] {
      SEL_SEQ,
      SEL_BRANCH,
      SEL_JUMP,
      SEL_HOLD
   } pc_sel_e;

   // Clear the sub-word offset bits so a redirect always lands on a word.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~PC_LOW_MASK;
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register: flush (NOP, invalid) beats hold, hold beats load.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            hold,
   input  logic [XLEN-1:0] instruction_in,
   input  logic [XLEN-1:0] pc_plus4_in,
   output logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] pc_plus4,
   output logic            valid
);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         instruction <= NOP_INSTR;
         pc_plus4    <= '0;
         valid       <= 1'b0;
      end else if (!hold) begin
         instruction <= instruction_in;
         pc_plus4    <= pc_plus4_in;
         valid       <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with branch/jump redirect, stall, target alignment,
// fetch counter and the IF/ID register feeding decode.
module fetch_pc_unit
   import pipeline_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [XLEN-1:0] PCPlus4,
   input  logic [XLEN-1:0] Instruction,
   input  logic            BranchTaken,
   input  logic [XLEN-1:0] BranchTarget,
   input  logic            Jump,
   input  logic [XLEN-1:0] JumpTarget,
   input  logic            Stall,
   output logic [XLEN-1:0] PCOut,
   output logic [XLEN-1:0] IF_ID_Instruction,
   output logic [XLEN-1:0] IF_ID_PCPlus4,
   output logic            IF_ID_Valid,
   output logic            Redirect,
   output logic            AlignFault,
   output logic [XLEN-1:0] FetchCount
);

   pc_sel_e         pc_sel;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] next_pc;
   logic            redirect;
   logic            misaligned;
   logic            load;

   // Branch is older than the jump in decode, so it takes priority.
   always_comb begin
      pc_sel = SEL_SEQ;
      target = JumpTarget;
      if (BranchTaken) begin
         pc_sel = SEL_BRANCH;
         target = BranchTarget;
      end else if (Jump) begin
         pc_sel = SEL_JUMP;
      end else if (Stall) begin
         pc_sel = SEL_HOLD;
      end
   end

   always_comb begin
      redirect   = (pc_sel == SEL_BRANCH) || (pc_sel == SEL_JUMP);
      misaligned = |(target & PC_LOW_MASK);
      load       = (pc_sel == SEL_SEQ);
      unique case (pc_sel)
         SEL_BRANCH,
         SEL_JUMP:  next_pc = align_word(target);
         SEL_HOLD:  next_pc = PCOut;
         default:   next_pc = PCPlus4;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         PCOut      <= RESET_PC;
         Redirect   <= 1'b0;
         AlignFault <= 1'b0;
         FetchCount <= '0;
      end else begin
         PCOut      <= next_pc;
         Redirect   <= redirect;
         AlignFault <= redirect && misaligned;
         if (load) begin
            FetchCount <= FetchCount + 32'd1;
         end
      end
   end

   if_id_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id_reg (
      .clk            (Clk),
      .reset          (Reset),
      .flush          (redirect),
      .hold           (pc_sel == SEL_HOLD),
      .instruction_in (Instruction),
      .pc_plus4_in    (PCPlus4),
      .instruction    (IF_ID_Instruction),
      .pc_plus4       (IF_ID_PCPlus4),
      .valid          (IF_ID_Valid)
   );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized self-checking bench for fetch_pc_unit against a cycle-level
// behavioural model of the fetch rules; directed scenarios run first.
module tb_fetch_pc_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] PCPlus4;
   logic [31:0] Instruction;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic        Stall;
   logic [31:0] PCOut;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;
   logic        Redirect;
   logic        AlignFault;
   logic [31:0] FetchCount;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Model state
   logic [31:0] m_pc, m_ins, m_p4, m_cnt;
   logic        m_valid, m_red, m_af;

   always #5 Clk = ~Clk;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Instruction memory and external PC adder
   assign Instruction = instr_of(PCOut);
   assign PCPlus4     = PCOut + 32'd4;

   fetch_pc_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .Clk               (Clk),
      .Reset             (Reset),
      .PCPlus4           (PCPlus4),
      .Instruction       (Instruction),
      .BranchTaken       (BranchTaken),
      .BranchTarget      (BranchTarget),
      .Jump              (Jump),
      .JumpTarget        (JumpTarget),
      .Stall             (Stall),
      .PCOut             (PCOut),
      .IF_ID_Instruction (IF_ID_Instruction),
      .IF_ID_PCPlus4     (IF_ID_PCPlus4),
      .IF_ID_Valid       (IF_ID_Valid),
      .Redirect          (Redirect),
      .AlignFault        (AlignFault),
      .FetchCount        (FetchCount)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the model one edge using the fetch rules directly.
   task automatic model_edge(input logic rst, input logic br, input logic [31:0] bt,
                             input logic j, input logic [31:0] jt, input logic st);
      logic [31:0] tgt;
      if (rst) begin
         m_pc = 0; m_ins = 0; m_p4 = 0; m_valid = 0; m_red = 0; m_af = 0; m_cnt = 0;
      end else if (br || j) begin
         tgt     = br ? bt : jt;
         m_red   = 1;
         m_af    = (tgt % 4) != 0;
         m_pc    = tgt - (tgt % 4);
         m_ins   = 0;
         m_p4    = 0;
         m_valid = 0;
      end else begin
         m_red = 0;
         m_af  = 0;
         if (!st) begin
            m_ins   = instr_of(m_pc);
            m_p4    = m_pc + 4;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
            m_pc    = m_pc + 4;
         end
      end
   endtask

   task automatic step(input logic rst, input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic st);
      Reset = rst; BranchTaken = br; BranchTarget = bt;
      Jump = j; JumpTarget = jt; Stall = st;
      @(posedge Clk);
      model_edge(rst, br, bt, j, jt, st);
      #1;
      check("pc",    PCOut,             m_pc);
      check("instr", IF_ID_Instruction, m_ins);
      check("pc4",   IF_ID_PCPlus4,     m_p4);
      check("valid", {31'd0, IF_ID_Valid}, {31'd0, m_valid});
      check("redir", {31'd0, Redirect},    {31'd0, m_red});
      check("afault",{31'd0, AlignFault},  {31'd0, m_af});
      check("count", FetchCount,        m_cnt);
      #3;
   endtask

   task automatic plain();
      step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      Reset = 1; BranchTaken = 0; BranchTarget = 0; Jump = 0; JumpTarget = 0; Stall = 0;
      m_pc = 0; m_ins = 0; m_p4 = 0; m_cnt = 0; m_valid = 0; m_red = 0; m_af = 0;
      @(negedge Clk);

      // Reset then sequential fetch
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("rst_pc", PCOut, 32'h0);
      check("rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
      plain();
      check("seq_pc4", PCOut, 32'h4);
      check("seq_if_pc4", IF_ID_PCPlus4, 32'h4);
      plain();
      check("seq_pc8", PCOut, 32'h8);

      // Branch at PC=8
      step(0, 1, 32'h40, 0, 0, 0);
      check("br_pc", PCOut, 32'h40);
      check("br_redirect", {31'd0, Redirect}, 32'd1);
      check("br_flush", {31'd0, IF_ID_Valid}, 32'd0);
      plain();
      check("br_target_pc4", IF_ID_PCPlus4, 32'h44);
      check("br_redirect_off", {31'd0, Redirect}, 32'd0);
      check("br_count", FetchCount, 32'd3);

      // Branch beats jump beats stall
      step(0, 1, 32'h100, 1, 32'h200, 1);
      check("prio_pc", PCOut, 32'h100);
      step(0, 0, 0, 1, 32'h10, 0);
      plain();
      // PC now 0x14; re-aim to 0x10 and stall there
      step(0, 0, 0, 1, 32'h10, 0);
      repeat (3) step(0, 0, 0, 0, 0, 1);
      check("stall_pc", PCOut, 32'h10);
      plain();
      check("unstall_pc", PCOut, 32'h14);

      // Unaligned jump
      step(0, 0, 0, 1, 32'h203, 0);
      check("align_pc", PCOut, 32'h200);
      check("align_fault", {31'd0, AlignFault}, 32'd1);
      plain();
      check("align_fault_off", {31'd0, AlignFault}, 32'd0);

      // PC wrap
      step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      plain();
      check("wrap_pc", PCOut, 32'h0);
      check("wrap_fault", {31'd0, AlignFault}, 32'd0);
      plain();

      // Reset during stall + jump
      step(1, 0, 0, 1, 32'h300, 1);
      check("midrst_pc", PCOut, 32'h0);
      check("midrst_count", FetchCount, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic        r, b, jj, s;
         logic [31:0] bt, jt;
         r  = ($urandom_range(0, 63) == 0);
         b  = ($urandom_range(0, 7) == 0);
         jj = ($urandom_range(0, 7) == 0);
         s  = ($urandom_range(0, 3) == 0);
         bt = $urandom();
         jt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom();
         step(r, b, bt, jj, jt, s);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
